// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store, data first with a fetch starvation guard
// Defining MEM_ARB_PERF_EN adds conflict, fetch-stall and guard-grant counters.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_conflict_cnt,
  output logic [31:0]     perf_i_stall_cnt,
  output logic [31:0]     perf_guard_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
  state_t state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic store_q, store_d;
  logic [DW-1:0] i_rdata_q, d_rdata_q;
  logic guard;
  always_comb begin
    guard = i_req && d_req && wait_cnt_q == MAX_W;
    i_gnt = reset && i_req && (!d_req || guard);
    d_gnt = reset && d_req && !i_gnt;
    mem_en = i_gnt || d_gnt;
    mem_we = d_gnt && d_we;
    mem_addr = i_gnt ? i_addr : d_addr;
    mem_wdata = d_wdata;
    mem_wmask = d_gnt ? d_wmask : '0;
    state_d = i_gnt ? RESP_I : d_gnt ? RESP_D : IDLE;
    store_d = d_gnt && d_we;
    wait_cnt_d = (!i_req || i_gnt) ? '0 : wait_cnt_q == MAX_W ? MAX_W : wait_cnt_q + 8'd1;
    i_rvalid = state_q == RESP_I;
    d_rvalid = state_q == RESP_D;
    i_rdata = i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata = (d_rvalid && !store_q) ? mem_rdata : d_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_cnt_q <= '0;
      store_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      store_q <= store_d;
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end
`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_q, stall_q, guard_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_q <= '0;
      stall_q <= '0;
      guard_q <= '0;
    end else begin
      conflict_q <= conflict_q + 32'(i_req && d_req);
      stall_q <= stall_q + 32'(i_req && !i_gnt);
      guard_q <= guard_q + 32'(guard);
    end
  end
  assign perf_conflict_cnt = conflict_q;
  assign perf_i_stall_cnt = stall_q;
  assign perf_guard_cnt = guard_q;
`endif
endmodule
